// File: rtl/delay_line_ctrl_pkg.sv
// Shared types and default geometry for the line-delay sequencer.
// No ports: state encoding plus default image and buffer constants.
package delay_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        FILL  = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam int IMG_W_DEF       = 640;
    localparam int IMG_H_DEF       = 480;
    localparam int DELAY_LINES_DEF = 8;
    localparam int FLUSH_CYC_DEF   = 4;
    localparam int CW_DEF          = 10;

endpackage

// File: rtl/delay_line_ctrl_if.sv
// Bundle between the sensor timing front-end and the delay sequencer.
// Ports: per_vsync/per_href/per_clken in; tap and status signals out.
interface delay_line_ctrl_if
    import delay_ctrl_pkg::*;
#(
    parameter int CW = CW_DEF
);
    logic          per_vsync;
    logic          per_href;
    logic          per_clken;
    logic          tap_clken;
    logic          tap_aclr;
    logic [CW-1:0] x_cnt;
    logic [CW-1:0] y_cnt;
    logic          line_done;
    logic          frame_done;
    logic          window_valid;
    logic          err_line_long;
    logic          err_line_short;

    modport master (
        output per_vsync, per_href, per_clken,
        input  tap_clken, tap_aclr, x_cnt, y_cnt,
        input  line_done, frame_done, window_valid,
        input  err_line_long, err_line_short
    );

    modport slave (
        input  per_vsync, per_href, per_clken,
        output tap_clken, tap_aclr, x_cnt, y_cnt,
        output line_done, frame_done, window_valid,
        output err_line_long, err_line_short
    );
endinterface

// File: rtl/sig_edge_det.sv
// Registers a level once and flags its rising/falling edges.
// Ports: clk, rst_n, d in; q (registered d), rise, fall out.
module sig_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic q_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= 1'b0;
            q_d <= 1'b0;
        end else begin
            q   <= d;
            q_d <= q;
        end
    end

    assign rise = q & ~q_d;
    assign fall = ~q & q_d;
endmodule

// File: rtl/delay_line_ctrl.sv
// Sequencer for the line-delay buffer: flush, fill, run, line/frame flags.
// Ports: clk, rst_n, bus (slave side of delay_line_ctrl_if).
module delay_line_ctrl
    import delay_ctrl_pkg::*;
#(
    parameter int IMG_W       = IMG_W_DEF,
    parameter int IMG_H       = IMG_H_DEF,
    parameter int DELAY_LINES = DELAY_LINES_DEF,
    parameter int FLUSH_CYC   = FLUSH_CYC_DEF,
    parameter int CW          = CW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    delay_line_ctrl_if.slave bus
);
    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam logic [CW-1:0] W_FULL = CW'(IMG_W);
    localparam logic [CW-1:0] W_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] H_LAST = CW'(IMG_H - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DELAY_LINES - 1);
    localparam logic [FW-1:0] F_LAST = FW'(FLUSH_CYC - 1);

    state_t state, state_nx;

    logic vs_q, vs_rise, vs_fall;
    logic hr_r, hr_rise, hr_fall;
    logic ce_r;
    logic active, eol, over;
    logic unused_sig;

    // pix counts accepted strobes (0..IMG_W); x_cnt clamps it to the last index
    logic [CW-1:0] pix;
    logic [CW-1:0] y_cnt;
    logic [FW-1:0] fl_cnt;

    sig_edge_det u_vs (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus.per_vsync),
        .q    (vs_q),
        .rise (vs_rise),
        .fall (vs_fall)
    );

    sig_edge_det u_hr (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (bus.per_href),
        .q    (hr_r),
        .rise (hr_rise),
        .fall (hr_fall)
    );

    assign unused_sig = ^{vs_q, vs_fall, hr_rise};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ce_r <= 1'b0;
        else        ce_r <= bus.per_clken;
    end

    assign active = (state == FILL) || (state == RUN);
    // a vsync rise on the same cycle as an href fall suppresses the line end
    assign eol    = hr_fall && active && !vs_rise;
    assign over   = ce_r && hr_r && active && (pix == W_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.tap_aclr  = 1'b0;
        bus.tap_clken = 1'b0;
        unique case (state)
            IDLE:  state_nx = IDLE;
            FLUSH: begin
                bus.tap_aclr = 1'b1;
                if (fl_cnt == F_LAST) state_nx = FILL;
            end
            FILL: begin
                bus.tap_clken = ce_r && hr_r && (pix < W_FULL);
                if (eol && y_cnt == D_LAST) state_nx = RUN;
            end
            RUN: begin
                bus.tap_clken = ce_r && hr_r && (pix < W_FULL);
                if (eol && y_cnt == H_LAST) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (vs_rise) state_nx = FLUSH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix                <= '0;
            y_cnt              <= '0;
            fl_cnt             <= '0;
            bus.line_done      <= 1'b0;
            bus.frame_done     <= 1'b0;
            bus.window_valid   <= 1'b0;
            bus.err_line_long  <= 1'b0;
            bus.err_line_short <= 1'b0;
        end else begin
            bus.line_done    <= eol;
            bus.frame_done   <= eol && (y_cnt == H_LAST);
            bus.window_valid <= bus.tap_clken && (state == RUN);
            fl_cnt <= (state == FLUSH && !vs_rise) ? fl_cnt + 1'b1 : '0;
            if (vs_rise) begin
                pix                <= '0;
                y_cnt              <= '0;
                bus.err_line_long  <= 1'b0;
                bus.err_line_short <= 1'b0;
            end else begin
                if (bus.tap_clken) pix <= pix + 1'b1;
                if (over) bus.err_line_long <= 1'b1;
                if (eol) begin
                    pix   <= '0;
                    y_cnt <= (y_cnt == H_LAST) ? '0 : y_cnt + 1'b1;
                    if (pix != W_FULL) bus.err_line_short <= 1'b1;
                end
            end
        end
    end

    assign bus.x_cnt = (pix == W_FULL) ? W_LAST : pix;
    assign bus.y_cnt = y_cnt;

endmodule
